pc_irq_gen: RTL

Parametrised, synthesizable PC-triggered interrupt stimulus generator for the CPU test harness. It watches the processor's instruction-address bus and, per channel, raises a hardware interrupt line after a programmable delay. The line stays up for a programmable width, or in level mode until acknowledged. It sits between the CPU's `addr` output and its `HWInt` inputs, replacing hand-written behavioural interrupt stimulus so that multi-source, repeated and back-to-back interrupt cases can be driven.

---
 rtl/pc_irq_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pc_irq_gen.sv
// pc_irq_gen: per-channel PC-triggered interrupt stimulus generator.
// Each channel watches the instruction-address bus and raises its irq line
// after a programmable delay. The line then stays high for a programmable
// width (pulse mode) or until it is acknowledged (level mode).
module pc_irq_gen #(
  parameter int N_CH   = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     en,
  input  logic                     clr,
  input  logic [N_CH*ADDR_W-1:0]   trig_pc,
  input  logic [N_CH*CNT_W-1:0]    delay,
  input  logic [N_CH*CNT_W-1:0]    hold,
  input  logic [2*N_CH-1:0]        mode,
  input  logic [N_CH-1:0]          ack,
  output logic [N_CH-1:0]          irq,
  output logic [N_CH-1:0]          fired,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ASSERT, DONE} state_t;

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  irq_d, fired_d;

  // Next-state, counter and pending-flag logic for every channel.
  always_comb begin
    logic             match, rearm, level, leave, pend_eff;
    logic [CNT_W-1:0] dly, hld, hld1;
    match    = 1'b0;
    rearm    = 1'b0;
    level    = 1'b0;
    leave    = 1'b0;
    pend_eff = 1'b0;
    dly      = '0;
    hld      = '0;
    hld1     = '0;
    pend_d   = pend_q;
    irq_d    = '0;
    fired_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      match    = en && (addr == trig_pc[i*ADDR_W +: ADDR_W]);
      rearm    = mode[2*i];
      level    = mode[2*i+1];
      dly      = delay[i*CNT_W +: CNT_W];
      hld      = hold[i*CNT_W +: CNT_W];
      hld1     = (hld == '0) ? CNT_W'(1) : hld;
      leave    = 1'b0;
      pend_eff = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (match) begin
            if (dly == '0) begin
              state_d[i] = ASSERT;
              cnt_d[i]   = hld1;
            end else begin
              state_d[i] = WAIT;
              cnt_d[i]   = dly;
            end
          end
        end
        WAIT: begin
          if (match && rearm) pend_d[i] = 1'b1;
          if (cnt_q[i] <= CNT_W'(1)) begin
            state_d[i] = ASSERT;
            cnt_d[i]   = hld1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ASSERT: begin
          // A match on the exit cycle is consumed immediately as the re-trigger,
          // so the pending flag is never left set in IDLE.
          pend_eff  = pend_q[i] | (match & rearm);
          pend_d[i] = pend_eff;
          leave     = level ? ack[i] : (cnt_q[i] <= CNT_W'(1));
          if (!leave) begin
            if (!level) cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end else if (!rearm) begin
            state_d[i] = DONE;
            cnt_d[i]   = '0;
          end else if (pend_eff) begin
            // Re-trigger goes through WAIT so irq drops for at least one cycle.
            pend_d[i]  = 1'b0;
            state_d[i] = WAIT;
            cnt_d[i]   = (dly == '0) ? CNT_W'(1) : dly;
          end else begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
        end
      endcase
      if (clr) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        pend_d[i]  = 1'b0;
      end
      irq_d[i]   = (state_d[i] == ASSERT);
      fired_d[i] = !clr && (fired[i] || irq_d[i]);
    end
  end

  // Channel state, counters, flags and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
      irq    <= '0;
      fired  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
      irq    <= irq_d;
      fired  <= fired_d;
    end
  end

  // Busy while any channel is counting down or asserting.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (state_q[i] == WAIT || state_q[i] == ASSERT) busy = 1'b1;
    end
  end

endmodule
